// File: rtl/rpn_sequencer.sv
// RPN token sequencer driving a stack-based ALU: pushes operands, folds operator results
// back onto the ALU stack, pops the final value and reports result/overflow/error.
module rpn_sequencer #(
  parameter int N         = 8,
  parameter int MAX_DEPTH = 1023,
  parameter int DEPTH_W   = 10
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         tok_valid,
  output logic         tok_ready,
  input  logic [1:0]   tok_kind,
  input  logic [N-1:0] tok_data,
  output logic [2:0]   alu_opcode,
  output logic [N-1:0] alu_data,
  input  logic [N-1:0] alu_result,
  input  logic         alu_ovf,
  output logic         res_valid,
  output logic [N-1:0] res_data,
  output logic         res_ovf,
  output logic         res_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_PUSH, S_ISSUE, S_WAIT, S_CAPT, S_POP1, S_POP2, S_PUSHR,
    S_FPOP, S_FWAIT, S_DONE, S_ERR, S_FLUSH
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_ADD  = 3'b100,
    OP_MUL  = 3'b101,
    OP_PUSH = 3'b110,
    OP_POP  = 3'b111
  } opcode_t;

  localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] ONE   = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] TWO   = DEPTH_W'(2);

  state_t               state_q, state_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d;
  opcode_t              opcode_q, opcode_d;
  logic [N-1:0]         adata_q, adata_d;
  logic [N-1:0]         tmp_q, tmp_d;
  logic                 sticky_q, sticky_d;
  logic                 res_valid_q, res_valid_d;
  logic [N-1:0]         res_data_q, res_data_d;
  logic                 res_ovf_q, res_ovf_d;
  logic                 res_err_q, res_err_d;
  logic                 accept;

  assign tok_ready  = (state_q == S_IDLE) && !res_valid_q;
  assign accept     = tok_valid && tok_ready;
  assign alu_opcode = opcode_q;
  assign alu_data   = adata_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_ovf    = res_ovf_q;
  assign res_err    = res_err_q;

  // Opcode/data are computed for the state being entered, so the registered
  // opcode is visible for exactly the cycle spent in that state.
  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    opcode_d    = OP_NOP;
    adata_d     = adata_q;
    tmp_d       = tmp_q;
    sticky_d    = sticky_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_ovf_d   = res_ovf_q;
    res_err_d   = res_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (tok_kind)
            2'b00: begin
              if (depth_q == MAX_D) begin
                state_d = S_ERR;
              end else begin
                state_d  = S_PUSH;
                opcode_d = OP_PUSH;
                adata_d  = tok_data;
                depth_d  = depth_q + ONE;
              end
            end
            2'b01, 2'b10: begin
              if (depth_q >= TWO) begin
                state_d  = S_ISSUE;
                opcode_d = (tok_kind == 2'b01) ? OP_ADD : OP_MUL;
              end else begin
                state_d = S_ERR;
              end
            end
            default: begin
              if (depth_q == ONE) begin
                state_d  = S_FPOP;
                opcode_d = OP_POP;
                depth_d  = depth_q - ONE;
              end else begin
                state_d = S_ERR;
              end
            end
          endcase
        end
      end
      S_PUSH:  state_d = S_IDLE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = S_CAPT;
      S_CAPT: begin
        tmp_d = alu_result;
        // x/z on alu_ovf compares false here and so never sets the sticky bit
        if (alu_ovf == 1'b1) sticky_d = 1'b1;
        state_d  = S_POP1;
        opcode_d = OP_POP;
        depth_d  = depth_q - ONE;
      end
      S_POP1: begin
        state_d  = S_POP2;
        opcode_d = OP_POP;
        depth_d  = depth_q - ONE;
      end
      S_POP2: begin
        state_d  = S_PUSHR;
        opcode_d = OP_PUSH;
        adata_d  = tmp_q;
        depth_d  = depth_q + ONE;
      end
      S_PUSHR: state_d = S_IDLE;
      S_FPOP:  state_d = S_FWAIT;
      S_FWAIT: state_d = S_DONE;
      S_DONE: begin
        res_valid_d = 1'b1;
        res_data_d  = alu_result;
        res_ovf_d   = sticky_q;
        res_err_d   = 1'b0;
        sticky_d    = 1'b0;
        state_d     = S_IDLE;
      end
      S_ERR: begin
        res_valid_d = 1'b1;
        res_ovf_d   = sticky_q;
        res_err_d   = 1'b1;
        sticky_d    = 1'b0;
        if (depth_q != '0) begin
          state_d  = S_FLUSH;
          opcode_d = OP_POP;
          depth_d  = depth_q - ONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (depth_q != '0) begin
          opcode_d = OP_POP;
          depth_d  = depth_q - ONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      depth_q     <= '0;
      opcode_q    <= OP_NOP;
      adata_q     <= '0;
      tmp_q       <= '0;
      sticky_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      opcode_q    <= opcode_d;
      adata_q     <= adata_d;
      tmp_q       <= tmp_d;
      sticky_q    <= sticky_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
      res_err_q   <= res_err_d;
    end
  end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Bench for rpn_sequencer: stack-ALU stub, expression-level reference model,
// directed literal cases and a randomized token stream.
module tb_rpn_sequencer;
  localparam int N    = 8;
  localparam int MAXD = 1023;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         tok_valid = 1'b0;
  logic         tok_ready;
  logic [1:0]   tok_kind = 2'b00;
  logic [N-1:0] tok_data = '0;
  logic [2:0]   alu_opcode;
  logic [N-1:0] alu_data;
  logic [N-1:0] alu_result;
  logic         alu_ovf;
  logic         res_valid;
  logic [N-1:0] res_data;
  logic         res_ovf;
  logic         res_err;

  rpn_sequencer #(.N(N), .MAX_DEPTH(MAXD), .DEPTH_W(10)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_kind(tok_kind), .tok_data(tok_data),
    .alu_opcode(alu_opcode), .alu_data(alu_data), .alu_result(alu_result), .alu_ovf(alu_ovf),
    .res_valid(res_valid), .res_data(res_data), .res_ovf(res_ovf), .res_err(res_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int errs = 0;
  int chks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Two's complement N-bit add/mul with signed-overflow flag
  function automatic void arith(input bit mul, input logic [N-1:0] a, input logic [N-1:0] b,
                                output logic [N-1:0] r, output bit o);
    int sa, sb, full;
    sa = int'($signed(a));
    sb = int'($signed(b));
    full = mul ? sa * sb : sa + sb;
    r = full[N-1:0];
    o = (full > (1 << (N-1)) - 1) || (full < -(1 << (N-1)));
  endfunction

  // ALU stub: registered output; add/mul peek the top two, pop returns the top
  logic [N-1:0] alu_stk[$];
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      alu_stk.delete();
      alu_result <= '0;
      alu_ovf    <= 1'b0;
    end else begin
      case (alu_opcode)
        3'b110: alu_stk.push_back(alu_data);
        3'b100, 3'b101: begin
          logic [N-1:0] r;
          bit o;
          check("alu_operands_present", 32'(alu_stk.size() >= 2), 32'd1);
          if (alu_stk.size() >= 2) begin
            arith(alu_opcode[0], alu_stk[$], alu_stk[$-1], r, o);
            alu_result <= r;
            alu_ovf    <= o;
          end
        end
        3'b111: begin
          check("alu_pop_nonempty", 32'(alu_stk.size() != 0), 32'd1);
          if (alu_stk.size() != 0) alu_result <= alu_stk.pop_back();
        end
        default: ;
      endcase
    end
  end

  // Expression-level reference model
  typedef struct { logic [N-1:0] d; bit o; bit e; } res_t;
  res_t         exp_q[$];
  logic [N-1:0] m_stk[$];
  bit           m_sticky = 1'b0;
  logic [N-1:0] m_last = '0;
  int exp_push = 0, exp_add = 0, exp_mul = 0, exp_pop = 0;
  int got_push = 0, got_add = 0, got_mul = 0, got_pop = 0;

  task automatic model_err();
    res_t x;
    x.d = m_last; x.o = m_sticky; x.e = 1'b1;
    exp_q.push_back(x);
    exp_pop += m_stk.size();
    m_stk.delete();
    m_sticky = 1'b0;
  endtask

  task automatic model_tok(input logic [1:0] k, input logic [N-1:0] d);
    logic [N-1:0] a, b, r;
    bit o;
    res_t x;
    case (k)
      2'b00: begin
        if (m_stk.size() == MAXD) model_err();
        else begin m_stk.push_back(d); exp_push++; end
      end
      2'b01, 2'b10: begin
        if (m_stk.size() < 2) model_err();
        else begin
          a = m_stk.pop_back();
          b = m_stk.pop_back();
          arith(k == 2'b10, a, b, r, o);
          m_sticky |= o;
          m_stk.push_back(r);
          if (k == 2'b01) exp_add++; else exp_mul++;
          exp_pop += 2;
          exp_push++;
        end
      end
      default: begin
        if (m_stk.size() == 1) begin
          r = m_stk.pop_back();
          x.d = r; x.o = m_sticky; x.e = 1'b0;
          exp_q.push_back(x);
          m_last = r;
          m_sticky = 1'b0;
          exp_pop++;
        end else model_err();
      end
    endcase
  endtask

  // Compare process
  logic [2:0]   trace[$];
  logic [N-1:0] last_d = '0;
  logic         last_o = 1'b0, last_e = 1'b0;
  int           res_edge = 0;
  int           n_res = 0;
  logic         prev_rv = 1'b0;
  always @(negedge CLK) begin
    if (RST_N) begin
      case (alu_opcode)
        3'b000: ;
        3'b110: got_push++;
        3'b100: got_add++;
        3'b101: got_mul++;
        3'b111: got_pop++;
        default: begin
          errs++;
          $display("FAIL opcode_legal: got %0b expected one of 000/100/101/110/111", alu_opcode);
        end
      endcase
      if (alu_opcode != 3'b000) trace.push_back(alu_opcode);
      if (res_valid) begin
        res_edge = cyc + 1;
        n_res++;
        last_d = res_data; last_o = res_ovf; last_e = res_err;
        check("res_pulse_single", 32'(prev_rv), 32'd0);
        check("res_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          res_t x;
          x = exp_q.pop_front();
          check("res_err", 32'(res_err), 32'(x.e));
          check("res_ovf", 32'(res_ovf), 32'(x.o));
          check("res_data", 32'(res_data), 32'(x.d));
        end
      end
      prev_rv = res_valid;
    end else prev_rv = 1'b0;
  end

  task automatic summary_fatal(input string why);
    errs++;
    $display("FAIL %s: timeout", why);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $fatal(1, "timeout");
  endtask

  task automatic send(input logic [1:0] k, input logic [N-1:0] d, output int acc_edge);
    int w;
    w = 0;
    @(negedge CLK);
    tok_valid = 1'b1; tok_kind = k; tok_data = d;
    while (!tok_ready) begin
      @(negedge CLK);
      w++;
      if (w > 5000) summary_fatal("send");
    end
    acc_edge = cyc + 1;
    @(posedge CLK);
    model_tok(k, d);
    #1;
    tok_valid = 1'b0;
    tok_kind  = 2'($urandom);
    tok_data  = N'($urandom);
  endtask

  task automatic quiesce();
    int w;
    w = 0;
    @(negedge CLK);
    while (!(tok_ready && exp_q.size() == 0)) begin
      @(negedge CLK);
      w++;
      if (w > 3000) summary_fatal("quiesce");
    end
  endtask

  logic [1:0]   qk[$];
  logic [N-1:0] qd[$];
  int           acc[$];

  task automatic run_q();
    int e;
    acc.delete();
    foreach (qk[i]) begin
      send(qk[i], qd[i], e);
      acc.push_back(e);
    end
    quiesce();
  endtask

  task automatic zero_counts();
    exp_push = 0; exp_add = 0; exp_mul = 0; exp_pop = 0;
    got_push = 0; got_add = 0; got_mul = 0; got_pop = 0;
  endtask

  initial begin
    logic [2:0] t1_ops[7];
    int e;
    t1_ops = '{3'b110, 3'b110, 3'b100, 3'b111, 3'b111, 3'b110, 3'b111};
    #1;
    check("rst_opcode", 32'(alu_opcode), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_err", 32'(res_err), 32'd0);
    repeat (3) @(posedge CLK);
    #2 RST_N = 1'b1;
    @(negedge CLK);
    check("rst_tok_ready", 32'(tok_ready), 32'd1);

    // 3,4,+,end
    trace.delete();
    qk = '{2'b00, 2'b00, 2'b01, 2'b11}; qd = '{8'd3, 8'd4, 8'd0, 8'd0};
    run_q();
    check("t1_data", 32'(last_d), 32'd7);
    check("t1_ovf", 32'(last_o), 32'd0);
    check("t1_err", 32'(last_e), 32'd0);
    check("t1_trace_len", 32'(trace.size()), 32'd7);
    if (trace.size() == 7) foreach (t1_ops[i]) check("t1_opcode", 32'(trace[i]), 32'(t1_ops[i]));
    check("lat_operand", 32'(acc[1] - acc[0]), 32'd2);
    check("lat_operator", 32'(acc[3] - acc[2]), 32'd7);
    check("lat_end", 32'(res_edge - acc[3]), 32'd4);
    check("t1_alu_empty", 32'(alu_stk.size()), 32'd0);

    // 3,4,*,2,+,end
    qk = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b11};
    qd = '{8'd3, 8'd4, 8'd0, 8'd2, 8'd0, 8'd0};
    run_q();
    check("t2_data", 32'(last_d), 32'd14);
    check("t2_ovf", 32'(last_o), 32'd0);
    check("t2_err", 32'(last_e), 32'd0);
    check("t2_alu_empty", 32'(alu_stk.size()), 32'd0);

    // 100,100,+,end then 1,1,+,end
    qk = '{2'b00, 2'b00, 2'b01, 2'b11}; qd = '{8'd100, 8'd100, 8'd0, 8'd0};
    run_q();
    check("t3_data", 32'(last_d), 32'hC8);
    check("t3_ovf", 32'(last_o), 32'd1);
    qd = '{8'd1, 8'd1, 8'd0, 8'd0};
    run_q();
    check("t3b_data", 32'(last_d), 32'd2);
    check("t3b_ovf", 32'(last_o), 32'd0);

    // 5,+ -> error, one flush pop
    zero_counts();
    qk = '{2'b00, 2'b01}; qd = '{8'd5, 8'd0};
    run_q();
    check("t4_err", 32'(last_e), 32'd1);
    check("t4_data_held", 32'(last_d), 32'd2);
    check("t4_pops", 32'(got_pop), 32'd1);
    check("t4_ready", 32'(tok_ready), 32'd1);

    // 1,2,end -> error, two pops; end alone -> error, no pops
    zero_counts();
    qk = '{2'b00, 2'b00, 2'b11}; qd = '{8'd1, 8'd2, 8'd0};
    run_q();
    check("t5_err", 32'(last_e), 32'd1);
    check("t5_pops", 32'(got_pop), 32'd2);
    zero_counts();
    e = n_res;
    qk = '{2'b11}; qd = '{8'd0};
    run_q();
    check("t5b_err", 32'(last_e), 32'd1);
    check("t5b_res_count", 32'(n_res - e), 32'd1);
    check("t5b_pops", 32'(got_pop), 32'd0);

    // Reset during POP1 of 3,4,+
    send(2'b00, 8'd3, e);
    send(2'b00, 8'd4, e);
    send(2'b01, 8'd0, e);
    begin
      int w;
      w = 0;
      @(negedge CLK);
      while (alu_opcode != 3'b111) begin
        @(negedge CLK);
        w++;
        if (w > 20) summary_fatal("wait_pop1");
      end
    end
    #2 RST_N = 1'b0;
    m_stk.delete(); m_sticky = 1'b0; m_last = '0; exp_q.delete();
    #1;
    check("t6_opcode", 32'(alu_opcode), 32'd0);
    check("t6_alu_data", 32'(alu_data), 32'd0);
    check("t6_res_valid", 32'(res_valid), 32'd0);
    check("t6_res_data", 32'(res_data), 32'd0);
    check("t6_res_ovf", 32'(res_ovf), 32'd0);
    check("t6_res_err", 32'(res_err), 32'd0);
    @(posedge CLK);
    #2 RST_N = 1'b1;
    zero_counts();
    @(negedge CLK);
    check("t6_ready_after", 32'(tok_ready), 32'd1);

    // MAX_DEPTH+1 operands -> error on the last, full flush
    for (int i = 0; i <= MAXD; i++) send(2'b00, N'($urandom), e);
    quiesce();
    check("depth_err", 32'(last_e), 32'd1);
    check("depth_data", 32'(last_d), 32'd0);
    check("depth_pushes", 32'(got_push), 32'(MAXD));
    check("depth_pops", 32'(got_pop), 32'(MAXD));

    // Randomized stream
    zero_counts();
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [1:0] k;
      r = int'($urandom_range(0, 99));
      k = (r < 45) ? 2'b00 : (r < 65) ? 2'b01 : (r < 85) ? 2'b10 : 2'b11;
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      send(k, N'($urandom), e);
    end
    quiesce();
    check("rnd_push", 32'(got_push), 32'(exp_push));
    check("rnd_add", 32'(got_add), 32'(exp_add));
    check("rnd_mul", 32'(got_mul), 32'(exp_mul));
    check("rnd_pop", 32'(got_pop), 32'(exp_pop));
    check("rnd_alu_depth", 32'(alu_stk.size()), 32'(m_stk.size()));
    check("rnd_pending", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
